// File: rtl/uart_rx_fifo.sv
// Oversampling serial receiver with glitch rejection, sticky error flags
// and a first-word-fall-through output FIFO.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ser_rx,
  input  logic [DIV_WIDTH-1:0]          cfg_divider,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  input  logic                          err_clear
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  function automatic logic parity_calc(input logic [DATA_BITS-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  state_t                 state_q, state_d;
  logic                   sync1_q, sync2_q, rx_prev_q;
  logic                   rx_s, fall_s, tick_s, last_data_s, last_stop_s, stop_bad_s;
  logic [DIV_WIDTH-1:0]   div_q, div_d, cnt_q, cnt_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_bad_q, par_bad_d, frm_bad_q, frm_bad_d;
  logic                   push_s, set_fe_s, set_pe_s;
  logic [7:0]             push_byte_s;
  logic [7:0]             mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic [7:0]             rd_data_q, rd_data_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   pop_s, full_s, push_acc_s, ovr_set_s;
  logic                   frame_err_q, frame_err_d, parity_err_q, parity_err_d;
  logic                   overrun_q, overrun_d;

  assign rx_s        = sync2_q;
  assign fall_s      = rx_prev_q & ~rx_s;
  assign tick_s      = (cnt_q == DIV_WIDTH'(1));
  assign last_data_s = (bit_cnt_q == 4'(DATA_BITS - 1));
  assign last_stop_s = (bit_cnt_q == 4'(STOP_BITS - 1));
  assign stop_bad_s  = frm_bad_q | ~rx_s;

  // Synchronizer, FSM state and receive datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= S_IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      bit_cnt_q <= 4'd0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
      frm_bad_q <= 1'b0;
    end else begin
      sync1_q   <= ser_rx;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
      frm_bad_q <= frm_bad_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (fall_s) state_d = S_START;
        else        state_d = S_IDLE;
      end
      S_START: begin
        if (tick_s) state_d = rx_s ? S_IDLE : S_DATA;
        else        state_d = S_START;
      end
      S_DATA: begin
        if (tick_s && last_data_s) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
        else                       state_d = S_DATA;
      end
      S_PARITY: begin
        if (tick_s) state_d = S_STOP;
        else        state_d = S_PARITY;
      end
      S_STOP: begin
        if (tick_s && last_stop_s) begin
          if (stop_bad_s) state_d = rx_s ? S_IDLE : S_WAIT_IDLE;
          else            state_d = S_IDLE;
        end else begin
          state_d = S_STOP;
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s) state_d = S_IDLE;
        else      state_d = S_WAIT_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bit timing, shift register and end-of-frame events; the divider is
  // captured at the start edge so mid-frame cfg changes are ignored.
  always_comb begin
    div_d     = div_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    frm_bad_d = frm_bad_q;
    push_s    = 1'b0;
    set_fe_s  = 1'b0;
    set_pe_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fall_s) begin
          div_d     = cfg_divider;
          cnt_d     = cfg_divider >> 1;
          bit_cnt_d = 4'd0;
          par_bad_d = 1'b0;
          frm_bad_d = 1'b0;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_START: begin
        if (tick_s) cnt_d = div_q;
        else        cnt_d = cnt_q - DIV_WIDTH'(1);
      end
      S_DATA: begin
        if (tick_s) begin
          cnt_d     = div_q;
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = last_data_s ? 4'd0 : bit_cnt_q + 4'd1;
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      S_PARITY: begin
        if (tick_s) begin
          cnt_d     = div_q;
          par_bad_d = (rx_s != parity_calc(shift_q, (PARITY == 1)));
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      S_STOP: begin
        if (tick_s) begin
          cnt_d     = div_q;
          frm_bad_d = stop_bad_s;
          if (last_stop_s) begin
            bit_cnt_d = 4'd0;
            set_fe_s  = stop_bad_s;
            push_s    = ~stop_bad_s;
            set_pe_s  = ~stop_bad_s & par_bad_q;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      S_WAIT_IDLE: cnt_d = cnt_q;
      default:     cnt_d = cnt_q;
    endcase
  end

  // FIFO control; the registered head is precomputed so rd_data is a flop.
  always_comb begin
    push_byte_s                  = 8'h00;
    push_byte_s[DATA_BITS-1:0]   = shift_q;
    pop_s      = rd_ready & rd_valid_q;
    full_s     = (level_q == LW'(FIFO_DEPTH));
    push_acc_s = push_s & (~full_s | pop_s);
    ovr_set_s  = push_s & full_s & ~pop_s;
    wr_ptr_d   = push_acc_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_acc_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    rd_valid_d = (level_d != '0);
    if (level_d == '0)                            rd_data_d = 8'h00;
    else if (push_acc_s && (wr_ptr_q == rd_ptr_d)) rd_data_d = push_byte_s;
    else                                          rd_data_d = mem_q[rd_ptr_d];
    frame_err_d  = set_fe_s  ? 1'b1 : (err_clear ? 1'b0 : frame_err_q);
    parity_err_d = set_pe_s  ? 1'b1 : (err_clear ? 1'b0 : parity_err_q);
    overrun_d    = ovr_set_s ? 1'b1 : (err_clear ? 1'b0 : overrun_q);
  end

  // FIFO storage, pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      rd_data_q    <= 8'h00;
      rd_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (push_acc_s) mem_q[wr_ptr_q] <= push_byte_s;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign fifo_level = level_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: 8N1, 8E1 and 5N2 instances share one clock;
// expected bytes go into a scoreboard queue and are compared on each pop.
module tb_uart_rx_fifo;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [15:0] cfg_divider;
  logic       ser_rx     [3];
  logic       rd_ready   [3];
  logic       err_clear  [3];
  logic [7:0] rd_data    [3];
  logic       rd_valid   [3];
  logic [3:0] fifo_level [3];
  logic       frame_err  [3];
  logic       parity_err [3];
  logic       overrun    [3];

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(8), .DIV_WIDTH(16)) u_8n1 (
    .clk(clk), .reset(reset), .ser_rx(ser_rx[0]), .cfg_divider(cfg_divider),
    .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .rd_ready(rd_ready[0]),
    .fifo_level(fifo_level[0]), .frame_err(frame_err[0]), .parity_err(parity_err[0]),
    .overrun(overrun[0]), .err_clear(err_clear[0]));

  uart_rx_fifo #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(8), .DIV_WIDTH(16)) u_8e1 (
    .clk(clk), .reset(reset), .ser_rx(ser_rx[1]), .cfg_divider(cfg_divider),
    .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .rd_ready(rd_ready[1]),
    .fifo_level(fifo_level[1]), .frame_err(frame_err[1]), .parity_err(parity_err[1]),
    .overrun(overrun[1]), .err_clear(err_clear[1]));

  uart_rx_fifo #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(8), .DIV_WIDTH(16)) u_5n2 (
    .clk(clk), .reset(reset), .ser_rx(ser_rx[2]), .cfg_divider(cfg_divider),
    .rd_data(rd_data[2]), .rd_valid(rd_valid[2]), .rd_ready(rd_ready[2]),
    .fifo_level(fifo_level[2]), .frame_err(frame_err[2]), .parity_err(parity_err[2]),
    .overrun(overrun[2]), .err_clear(err_clear[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_check(input int idx, input string tag);
    logic [7:0] e;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    else                   e = 8'hxx;
    check({tag, "_valid"}, 32'(rd_valid[idx]), 32'd1);
    check({tag, "_data"}, 32'(rd_data[idx]), 32'(e));
    rd_ready[idx] = 1'b1;
    @(negedge clk);
    rd_ready[idx] = 1'b0;
  endtask

  task automatic drain(input int idx, input string tag);
    while (exp_q.size() != 0) pop_check(idx, tag);
    check({tag, "_empty_valid"}, 32'(rd_valid[idx]), 32'd0);
    check({tag, "_empty_level"}, 32'(fifo_level[idx]), 32'd0);
  endtask

  task automatic clear_errs(input int idx);
    err_clear[idx] = 1'b1;
    @(negedge clk);
    err_clear[idx] = 1'b0;
  endtask

  // Drives one frame starting at a negedge; optionally pops once at local
  // cycle pulse_at (counted in negedges from the start bit).
  task automatic send_frame(input int idx, input logic [7:0] data, input int nd,
                            input bit has_par, input logic par_bit,
                            input logic [1:0] stop_v, input int ns, input int pulse_at);
    logic bits [12];
    int nb;
    int k;
    logic [7:0] e;
    bits[0] = 1'b0;
    nb = 1;
    for (int i = 0; i < nd; i++) begin bits[nb] = data[i]; nb = nb + 1; end
    if (has_par) begin bits[nb] = par_bit; nb = nb + 1; end
    for (int i = 0; i < ns; i++) begin bits[nb] = stop_v[i]; nb = nb + 1; end
    k = 0;
    for (int b = 0; b < nb; b++) begin
      ser_rx[idx] = bits[b];
      for (int c = 0; c < DIV; c++) begin
        if (k == pulse_at) begin
          if (exp_q.size() != 0) e = exp_q.pop_front();
          else                   e = 8'hxx;
          check("pulse_valid", 32'(rd_valid[idx]), 32'd1);
          check("pulse_data", 32'(rd_data[idx]), 32'(e));
          rd_ready[idx] = 1'b1;
        end else if (k == pulse_at + 1) begin
          rd_ready[idx] = 1'b0;
        end
        @(negedge clk);
        k = k + 1;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    cfg_divider = 16'(DIV);
    for (int i = 0; i < 3; i++) begin
      ser_rx[i] = 1'b1; rd_ready[i] = 1'b0; err_clear[i] = 1'b0;
    end
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(1);

    for (int i = 0; i < 3; i++) begin
      check("rst_valid", 32'(rd_valid[i]), 32'd0);
      check("rst_level", 32'(fifo_level[i]), 32'd0);
      check("rst_data", 32'(rd_data[i]), 32'd0);
      check("rst_errs", {29'd0, frame_err[i], parity_err[i], overrun[i]}, 32'd0);
    end

    // 8N1 single byte
    exp_q.push_back(8'h55);
    send_frame(0, 8'h55, 8, 1'b0, 1'b0, 2'b11, 1, -1);
    check("b55_level", 32'(fifo_level[0]), 32'd1);
    check("b55_errs", {29'd0, frame_err[0], parity_err[0], overrun[0]}, 32'd0);
    drain(0, "b55");

    // Short glitch
    ser_rx[0] = 1'b0;
    wait_cycles(4);
    ser_rx[0] = 1'b1;
    wait_cycles(40);
    check("glitch_level", 32'(fifo_level[0]), 32'd0);
    check("glitch_errs", {29'd0, frame_err[0], parity_err[0], overrun[0]}, 32'd0);

    // Bad stop followed by a break, then a good byte
    send_frame(0, 8'h3C, 8, 1'b0, 1'b0, 2'b00, 1, -1);
    check("brk_ferr", 32'(frame_err[0]), 32'd1);
    check("brk_level", 32'(fifo_level[0]), 32'd0);
    clear_errs(0);
    check("brk_clear", 32'(frame_err[0]), 32'd0);
    wait_cycles(3 * DIV - 1);
    ser_rx[0] = 1'b1;
    wait_cycles(40);
    check("brk_single_ferr", 32'(frame_err[0]), 32'd0);
    check("brk_no_bytes", 32'(fifo_level[0]), 32'd0);
    exp_q.push_back(8'h7E);
    send_frame(0, 8'h7E, 8, 1'b0, 1'b0, 2'b11, 1, -1);
    check("b7e_level", 32'(fifo_level[0]), 32'd1);
    drain(0, "b7e");

    // Overrun: nine bytes into an eight-deep FIFO with no reader
    for (int b = 0; b < 9; b++) begin
      if (b < 8) exp_q.push_back(8'(b));
      send_frame(0, 8'(b), 8, 1'b0, 1'b0, 2'b11, 1, -1);
    end
    check("ovr_flag", 32'(overrun[0]), 32'd1);
    check("ovr_level", 32'(fifo_level[0]), 32'd8);
    drain(0, "ovr");
    clear_errs(0);
    check("ovr_clear", 32'(overrun[0]), 32'd0);

    // Full FIFO with a pop in the same cycle as the ninth push
    for (int b = 0; b < 8; b++) begin
      exp_q.push_back(8'(b));
      send_frame(0, 8'(b), 8, 1'b0, 1'b0, 2'b11, 1, -1);
    end
    exp_q.push_back(8'h08);
    send_frame(0, 8'h08, 8, 1'b0, 1'b0, 2'b11, 1, 154);
    check("pp_no_ovr", 32'(overrun[0]), 32'd0);
    check("pp_level", 32'(fifo_level[0]), 32'd8);
    drain(0, "pp");

    // 8E1: 0xA5 has even ones, so parity bit 1 is wrong
    exp_q.push_back(8'hA5);
    send_frame(1, 8'hA5, 8, 1'b1, 1'b1, 2'b11, 1, -1);
    check("par_perr", 32'(parity_err[1]), 32'd1);
    check("par_ferr", 32'(frame_err[1]), 32'd0);
    check("par_level", 32'(fifo_level[1]), 32'd1);
    clear_errs(1);
    check("par_clear", 32'(parity_err[1]), 32'd0);
    exp_q.push_back(8'h07);
    send_frame(1, 8'h07, 8, 1'b1, 1'b1, 2'b11, 1, -1);
    check("par_good", 32'(parity_err[1]), 32'd0);
    drain(1, "par");

    // 5N2: second stop bit low, then a good byte, then reset mid-frame
    send_frame(2, 8'h1F, 5, 1'b0, 1'b0, 2'b01, 2, -1);
    ser_rx[2] = 1'b1;
    wait_cycles(20);
    check("s2_ferr", 32'(frame_err[2]), 32'd1);
    check("s2_level", 32'(fifo_level[2]), 32'd0);
    send_frame(2, 8'h13, 5, 1'b0, 1'b0, 2'b11, 2, -1);
    check("b13_data", 32'(rd_data[2]), 32'h13);
    check("b13_level", 32'(fifo_level[2]), 32'd1);
    ser_rx[2] = 1'b0;
    wait_cycles(DIV + 24);
    reset = 1'b1;
    ser_rx[2] = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(1);
    exp_q.delete();
    check("mid_rst_level", 32'(fifo_level[2]), 32'd0);
    check("mid_rst_valid", 32'(rd_valid[2]), 32'd0);
    check("mid_rst_errs", {29'd0, frame_err[2], parity_err[2], overrun[2]}, 32'd0);
    wait_cycles(10);
    exp_q.push_back(8'h0A);
    send_frame(2, 8'h0A, 5, 1'b0, 1'b0, 2'b11, 2, -1);
    check("b0a_level", 32'(fifo_level[2]), 32'd1);
    drain(2, "b0a");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
